// File: rtl/led_shift_tx_pkg.sv
// Shared types and defaults for the LED shift transmitter.
// Optional feature macro: LED_SHIFT_TX_CHANGE_DETECT_EN.
package led_shift_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_CLK_DIV = 4;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_shift_tx_tick.sv
// Clock divider for led_shift_tx: one-cycle tick every CLK_DIV
// enabled clocks, restartable so each frame starts phase-aligned.
module led_shift_tx_tick
  import led_shift_tx_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int DW = cnt_w(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && !restart && (cnt == LAST);

endmodule

// File: rtl/led_shift_tx.sv
// Serial LED pattern transmitter: MSB-first shift plus latch strobe.
// Define LED_SHIFT_TX_CHANGE_DETECT_EN to auto-send on data change.
module led_shift_tx
  import led_shift_tx_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             sclk,
  output logic             sdata,
  output logic             latch
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LASTB = BW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bcnt;
  logic             sclk_q;
  logic             tick;
  logic             start;
  logic             accept;
  logic             last_bit;

`ifdef LED_SHIFT_TX_CHANGE_DETECT_EN
  logic [WIDTH-1:0] prev;

  assign start = (data != prev);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev <= '0;
    end else if (accept) begin
      prev <= data;
    end
  end
`else
  assign start = valid;
`endif

  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (bcnt == LASTB);

  led_shift_tx_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q != IDLE),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick && sclk_q && last_bit)
          state_d = LATCH;
      end
      LATCH: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit 0 stays at the MSB position through LATCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg   <= '0;
      bcnt   <= '0;
      sclk_q <= 1'b0;
    end else if (accept) begin
      sreg   <= data;
      bcnt   <= '0;
      sclk_q <= 1'b0;
    end else if (state_q == SHIFT && tick) begin
      if (!sclk_q) begin
        sclk_q <= 1'b1;
      end else begin
        sclk_q <= 1'b0;
        bcnt   <= bcnt + 1'b1;
        if (!last_bit) sreg <= sreg << 1;
      end
    end
  end

  always_comb begin
    ready = 1'b0;
    latch = 1'b0;
    sdata = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): ready = 1'b1;
      (state_q == SHIFT): sdata = sreg[WIDTH-1];
      (state_q == LATCH): begin
        latch = 1'b1;
        sdata = sreg[WIDTH-1];
      end
      default: ;
    endcase
  end

  assign sclk = sclk_q;

endmodule

// File: tb/tb_led_shift_tx.sv
// Self-checking bench for led_shift_tx against a timing model
// derived from the frame rules (bit slots, latch window, ready).
module tb_led_shift_tx;

  localparam int W = 16;
  localparam int C = 4;
  localparam int NSH = 2 * W * C;
  localparam int FRAME = 1 + (2 * W + 1) * C;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] data = '0;
  logic         valid = 1'b0;
  logic         ready;
  logic         sclk;
  logic         sdata;
  logic         latch;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lcnt = 0;
  logic ps = 1'b0;
  logic pl = 1'b0;
  logic bitq[$];

  led_shift_tx #(
    .WIDTH   (W),
    .CLK_DIV (C)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .sclk  (sclk),
    .sdata (sdata),
    .latch (latch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sclk === 1'b1 && ps === 1'b0) bitq.push_back(sdata);
    if (latch === 1'b1 && pl === 1'b0) lcnt = lcnt + 1;
    ps = sclk;
    pl = latch;
  end

  initial begin
    #300000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {sclk, sdata, latch, ready};
  endfunction

  // Expected {sclk,sdata,latch,ready} in cycle rel of a frame.
  function automatic logic [3:0] model(input logic [W-1:0] d,
                                       input int rel);
    int i;
    logic hi;
    if (rel <= NSH) begin
      i = (rel - 1) / (2 * C);
      hi = ((rel - 1) % (2 * C)) >= C;
      return {hi, d[W-1-i], 1'b0, 1'b0};
    end else if (rel < FRAME) begin
      return {1'b0, d[0], 1'b1, 1'b0};
    end
    return 4'b0001;
  endfunction

  task automatic start_frame(input logic [W-1:0] d,
                             input logic v,
                             output int acc);
    int n;
    n = 0;
    @(negedge clk);
    data = d;
    valid = v;
    while (ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", ready, 1);
    acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic check_frame(input logic [W-1:0] d,
                             input int acc,
                             input int chg_rel,
                             input logic [W-1:0] chg_d,
                             input logic keep_v,
                             input string tag);
    int l0;
    logic [W-1:0] word;
    l0 = lcnt;
    bitq.delete();
    chk({tag, "_start"}, cyc - acc + 1, 1);
    for (int rel = 1; rel <= FRAME; rel++) begin
      chk($sformatf("%s_c%0d", tag, rel), outs(), model(d, rel));
      if (rel == 1) valid = keep_v;
      if (rel == chg_rel) data = chg_d;
      if (rel < FRAME) @(negedge clk);
    end
    #1;
    word = '0;
    foreach (bitq[k]) word = {word[W-2:0], bitq[k]};
    chk({tag, "_nbits"}, bitq.size(), W);
    chk({tag, "_bits"}, word, d);
    chk({tag, "_latches"}, lcnt - l0, 1);
  endtask

  task automatic quiet(input int n, input string tag);
    int bad;
    int l0;
    bad = 0;
    l0 = lcnt;
    bitq.delete();
    repeat (n) begin
      @(negedge clk);
      if (outs() !== 4'b0001) bad++;
    end
    chk({tag, "_badcyc"}, bad, 0);
    chk({tag, "_latches"}, lcnt - l0, 0);
    chk({tag, "_sclk"}, bitq.size(), 0);
  endtask

  initial begin
    int acc;
    int acc2;
    int l0;
    logic [W-1:0] d;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hold", outs(), 4'b0001);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release", outs(), 4'b0001);
    quiet(200, "idle");

`ifdef LED_SHIFT_TX_CHANGE_DETECT_EN
    start_frame(16'h00FF, 1'b0, acc);
    check_frame(16'h00FF, acc, 0, '0, 1'b0, "cd1");
    quiet(200, "cd_hold");
    start_frame(16'h0F0F, 1'b0, acc);
    check_frame(16'h0F0F, acc, 0, '0, 1'b0, "cd2");
    quiet(50, "cd_end");
`else
    start_frame(16'hA5C3, 1'b1, acc);
    check_frame(16'hA5C3, acc, 0, '0, 1'b0, "single");

    start_frame(16'h0001, 1'b1, acc);
    check_frame(16'h0001, acc, 10, 16'hFFFF, 1'b0, "stab");

    for (int k = 0; k < 4; k++) begin
      d = W'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      start_frame(d, 1'b1, acc);
      check_frame(d, acc, 0, '0, 1'b0, $sformatf("rnd%0d", k));
    end

    start_frame(16'hFFFF, 1'b1, acc);
    valid = 1'b0;
    repeat (49) @(negedge clk);
    chk("mid_pre", outs(), model(16'hFFFF, 50));
    l0 = lcnt;
    #1 rst = 1'b0;
    #1 chk("mid_rst", outs(), 4'b0001);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ready", ready, 1);
    quiet(200, "mid_after");
    chk("mid_nolatch", lcnt - l0, 0);

    l0 = lcnt;
    start_frame(16'h8000, 1'b1, acc);
    check_frame(16'h8000, acc, 1, 16'h0001, 1'b1, "b2b1");
    acc2 = cyc + 1;
    chk("b2b_gap", acc2 - acc, FRAME);
    @(negedge clk);
    check_frame(16'h0001, acc2, 0, '0, 1'b0, "b2b2");
    quiet(20, "b2b_end");
    chk("b2b_latches", lcnt - l0, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/led_shift_tx.md
# led_shift_tx

Serial transmitter that drives the board's LED display from the 16-bit parallel pattern produced by the animation logic. It accepts a pattern over a valid/ready handshake and shifts it out MSB-first on a shift-clock/data pair. It then pulses a latch strobe so the external shift-register chain updates all LEDs at once. It sits between the animation block's `led` bus and the display pins.

## Interface

- `WIDTH`, 16, number of pattern bits per frame (≥1)
- `CLK_DIV`, 4, system clocks per `sclk` half-period (≥1)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `data`  in  WIDTH  pattern to transmit; bit WIDTH-1 is shifted first
- `valid`  in  1  `data` is offered
- `ready`  out  1  block can accept a frame
- `sclk`  out  1  shift clock to display; data is sampled on its rising edge
- `sdata`  out  1  serial data
- `latch`  out  1  storage-register strobe, active high

## Operation

- **Reset values:** `sclk`=0, `sdata`=0, `latch`=0, `ready`=1, FSM in IDLE, shift register cleared.
- **FSM states:**
  - **IDLE:** `ready`=1. When `valid`&&`ready` is true at a rising edge, `data` is captured into the shift register and the FSM goes to SHIFT. `ready` drops in the next cycle.
  - **SHIFT:** each bit lasts 2·CLK_DIV clocks. `sdata` presents the bit while `sclk` is low for CLK_DIV clocks, then `sclk` is high for CLK_DIV clocks. After WIDTH bits the FSM goes to LATCH.
  - **LATCH:** `sclk`=0 and `latch`=1 for CLK_DIV clocks, then back to IDLE.
- `sdata` holds the last bit (bit 0) during LATCH and returns to 0 in IDLE.
- **Input capture:** `data` is sampled only at the acceptance edge. Later changes to `data` or `valid` do not affect the frame in flight.
- **Counters:**
  - Divider counter width is $clog2(CLK_DIV), minimum 1; it wraps from CLK_DIV-1 to 0.
  - Bit counter width is $clog2(WIDTH+1).
- **Reset mid-frame:** all outputs take their reset values asynchronously. No latch pulse is issued and the partial frame is discarded.
- **Back-to-back frames:** `valid` held high with new data starts the next frame on the first cycle `ready`=1. No idle gap beyond that one cycle.

## Timing

- The acceptance edge is cycle 0.
- Cycle 1: `sdata`=bit WIDTH-1, `sclk`=0.
- First `sclk` rising edge: cycle 1+CLK_DIV.
- Last `sclk` falling edge, which is also `latch` rising: cycle 1+2·WIDTH·CLK_DIV.
- `latch` is high for CLK_DIV cycles.
- `ready` reasserts at cycle 1+(2·WIDTH+1)·CLK_DIV. With defaults (WIDTH=16, CLK_DIV=4) this is cycle 133.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- **`LED_SHIFT_TX_CHANGE_DETECT_EN`:**
  - **Defined:** the block keeps a copy of the last transmitted pattern. In IDLE it starts a frame by itself whenever `data` differs from that copy; `valid` is ignored. The copy resets to 0, so a nonzero `data` after reset triggers a frame automatically.
  - **Undefined:** only the valid/ready handshake starts frames, and the copy register is not built.

## Structure

- **Shared package `led_shift_tx_pkg`:**
  - FSM state encoding: IDLE=2'd0, SHIFT=2'd1, LATCH=2'd2.
  - Default WIDTH/CLK_DIV constants.
- **One sub-module, `led_shift_tx_tick`:**
  - Parameterised CLK_DIV divider.
  - Has an enable input and a synchronous restart.
  - Emits a one-cycle `tick` every CLK_DIV enabled clocks.
  - The FSM toggles `sclk` and advances bits on `tick`.

## Test plan

- **Reset:** assert `rst`=0 for 2 cycles, release → `ready`=1, `sclk`=`sdata`=`latch`=0; no activity for 200 cycles with `valid`=0.
- **Single frame:** `data`=16'hA5C3, `valid` pulsed for 1 cycle (defaults) → a bench sampler on `sclk` rising edges collects 1010_0101_1100_0011 in order. `latch` is high cycles 129–132 and `ready` returns at cycle 133.
- **Input stability:** change `data` to 16'hFFFF at cycle 10 of a 16'h0001 frame → the shifted bits are still 16'h0001.
- **Back-to-back:** `valid` held high, `data`=16'h8000 then 16'h0001 → two frames, second accepted at cycle 133, exactly 2 latch pulses.
- **Reset mid-frame:** assert reset at cycle 50 → outputs are 0 immediately. No `latch` pulse occurs, and `ready`=1 after release.
- **Change detect (`LED_SHIFT_TX_CHANGE_DETECT_EN`):** `valid`=0, `data` goes 0 → 16'h00FF → one frame is sent. `data` is held at 16'h00FF → no further frames. `data` goes to 16'h0F0F → one more frame.
